cus19_load_unit: RTL and testbench

- Memory-read counterpart of the M-type store path, used in the IE stage for `LD r1, addr`.
- Takes an 11-bit address from the instruction and issues a read request to Data Memory with a request/grant/valid handshake.
- Captures the returned 8-bit byte and writes it back to the register file as a one-cycle write pulse.
- Stalls the pipeline for the whole time a load is outstanding.

---
 rtl/cus19_load_unit.sv | 133 +++++++++++++
 tb/tb_cus19_load_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cus19_load_unit.sv
// cus19_load_unit: IE-stage load path for `LD r1, addr`.
// Issues a Data Memory read with a req/gnt/valid handshake, captures the
// returned byte and writes it back to the register file as a one-cycle pulse.
// The pipeline is stalled while a load is outstanding.
// Optional feature: define CUS19_LD_TIMEOUT_EN to abort a load that stays in
// REQ/WAIT for TIMEOUT_CYCLES cycles (ld_err_out pulses once).
module cus19_load_unit #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 8,
    parameter int REG_W          = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_in,
    input  logic [ADDR_W-1:0] imm_addr_in,
    input  logic [REG_W-1:0]  rd_idx_in,
    output logic [ADDR_W-1:0] dm_rd_addr_out,
    output logic              dm_read_req,
    input  logic              dm_rd_gnt_in,
    input  logic              dm_rd_valid_in,
    input  logic [DATA_W-1:0] dm_rd_data_in,
    output logic              rf_wr_en_out,
    output logic [REG_W-1:0]  rf_wr_addr_out,
    output logic [DATA_W-1:0] rf_wr_data_out,
    output logic              ld_stall_out,
    output logic              ld_err_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [REG_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              capture;
    logic              abort;

`ifdef CUS19_LD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;
    logic       err_q;
`endif

    // Next-state logic; a completion in the expiry cycle takes priority over abort.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd_in) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Valid without grant is not ours yet, so it is ignored here.
                if (dm_rd_gnt_in && dm_rd_valid_in) begin
                    capture   = 1'b1;
                    state_nxt = WB;
                end else if (dm_rd_gnt_in) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dm_rd_valid_in) begin
                    capture   = 1'b1;
                    state_nxt = WB;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef CUS19_LD_TIMEOUT_EN
        if ((state == REQ || state == WAIT) && !capture && tmo_cnt == TMO_LAST) begin
            abort     = 1'b1;
            state_nxt = IDLE;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch address/index on accept, data on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= imm_addr_in;
                idx_q  <= rd_idx_in;
            end
            if (capture) data_q <= dm_rd_data_in;
        end
    end

`ifdef CUS19_LD_TIMEOUT_EN
    // Cycles spent in REQ/WAIT for the current load, and the one-cycle abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept)                            tmo_cnt <= '0;
            else if (state == REQ || state == WAIT) tmo_cnt <= tmo_cnt + 8'd1;
            err_q <= abort;
        end
    end
    assign ld_err_out = err_q;
`else
    assign ld_err_out = 1'b0;
`endif

    // Outputs decode only registered state, so they are clean the cycle after reset.
    always_comb begin
        dm_read_req    = (state == REQ);
        dm_rd_addr_out = (state == REQ || state == WAIT) ? addr_q : '0;
        rf_wr_en_out   = (state == WB);
        rf_wr_addr_out = (state == WB) ? idx_q  : '0;
        rf_wr_data_out = (state == WB) ? data_q : '0;
        ld_stall_out   = (state != IDLE);
    end

endmodule

// File: tb/tb_cus19_load_unit.sv
// Self-checking bench for cus19_load_unit: table of directed loads, reset and
// timeout sequences, then randomized traffic, all checked every cycle against
// a transaction-level model of the outstanding load.
module tb_cus19_load_unit;

`ifdef CUS19_LD_TIMEOUT_EN
    localparam int TMO_P  = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO_P  = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, mem_rd, gnt, valid, req, wr_en, stall, err;
    logic [10:0] imm, dm_addr;
    logic [2:0]  rd, waddr;
    logic [7:0]  rdata, wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cus19_load_unit #(.TIMEOUT_CYCLES(TMO_P)) dut (
        .clk(clk), .rst(rst), .mem_rd_in(mem_rd), .imm_addr_in(imm), .rd_idx_in(rd),
        .dm_rd_addr_out(dm_addr), .dm_read_req(req), .dm_rd_gnt_in(gnt),
        .dm_rd_valid_in(valid), .dm_rd_data_in(rdata), .rf_wr_en_out(wr_en),
        .rf_wr_addr_out(waddr), .rf_wr_data_out(wdata), .ld_stall_out(stall),
        .ld_err_out(err)
    );

    // Model: one outstanding load record.
    bit          m_active = 0, m_granted = 0, m_wb = 0, m_err = 0;
    logic [10:0] m_addr = '0;
    logic [2:0]  m_idx = '0;
    logic [7:0]  m_data = '0;
    int          m_waited = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit done, new_err;
        new_err = 0;
        if (rst) begin
            m_active = 0; m_granted = 0; m_wb = 0;
        end else if (m_wb) begin
            m_active = 0; m_wb = 0;
        end else if (!m_active) begin
            if (mem_rd) begin
                m_active = 1; m_granted = 0; m_waited = 0;
                m_addr = imm; m_idx = rd;
            end
        end else begin
            done = m_granted ? valid : (gnt && valid);
            if (gnt) m_granted = 1;
            if (done) begin
                m_data = rdata; m_wb = 1;
            end else begin
                m_waited++;
                if (TMO_EN && m_waited == TMO_P) begin
                    m_active = 0; new_err = 1;
                end
            end
        end
        m_err = new_err;
    endtask

    task automatic check_outputs();
        logic [25:0] act, exp;
        bit busy;
        busy = m_active && !m_wb;
        act = {req, dm_addr, wr_en, waddr, wdata, stall, err};
        exp = {busy && !m_granted, busy ? m_addr : 11'h0, m_wb,
               m_wb ? m_idx : 3'h0, m_wb ? m_data : 8'h0, m_active, m_err};
        cmp("cycle_outputs", 32'(act), 32'(exp));
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        logic [10:0] addr;
        logic [2:0]  idx;
        int          gw;       // REQ cycles with grant low
        int          vw;       // cycles from grant to valid (0 = same cycle)
        logic [7:0]  data;
        bit          prevalid; // pulse valid before grant
        bit          poke;     // toggle mem_rd / imm in WAIT
        bit          b2b_next; // assert next row's load during this WB
        int          exp_lat;  // cycles from accept edge to write cycle
    } row_t;

    row_t rows[5];

    task automatic run_row(input int r);
        int lat, stall_n, gc, vc;
        mem_rd = 1; imm = rows[r].addr; rd = rows[r].idx; gnt = 0; valid = 0;
        tick();
        mem_rd = 0; imm = 11'($urandom); rd = 3'($urandom);
        lat = 0; stall_n = 0;
        gc = rows[r].gw + 1;
        vc = gc + rows[r].vw;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            if (stall) stall_n++;
            if (wr_en) begin
                lat = c;
                cmp("wb_addr", 32'(waddr), 32'(rows[r].idx));
                cmp("wb_data", 32'(wdata), 32'(rows[r].data));
            end else begin
                cmp("held_addr", 32'(dm_addr), 32'(rows[r].addr));
                gnt   = (c == gc);
                valid = (c == vc) || (rows[r].prevalid && c == 1 && rows[r].gw > 0);
                rdata = (c == vc) ? rows[r].data : 8'hEE;
                if (rows[r].poke && c > gc) begin
                    mem_rd = 1; imm = 11'h001;
                end
                tick();
            end
        end
        cmp("latency", 32'(lat), 32'(rows[r].exp_lat));
        cmp("stall_cycles", 32'(stall_n), 32'(rows[r].exp_lat));
        gnt = 0; valid = 0; mem_rd = 0;
        if (rows[r].b2b_next && r < 4) begin
            mem_rd = 1; imm = rows[r+1].addr; rd = rows[r+1].idx;
        end
        tick();
        cmp("idle_stall", 32'(stall), 32'h0);
        cmp("idle_wr", 32'(wr_en), 32'h0);
    endtask

    initial begin
        int c_err;
        rows[0] = '{11'h7FF, 3'd3, 0, 0, 8'hA5, 0, 0, 0, 2};
        rows[1] = '{11'h123, 3'd5, 3, 4, 8'h3C, 0, 0, 0, 9};
        rows[2] = '{11'h2AA, 3'd6, 2, 3, 8'h77, 1, 1, 0, 7};
        rows[3] = '{11'h010, 3'd1, 0, 1, 8'h11, 0, 0, 1, 3};
        rows[4] = '{11'h011, 3'd2, 1, 0, 8'h22, 0, 0, 0, 3};

        rst = 1; mem_rd = 0; imm = '0; rd = '0; gnt = 0; valid = 0; rdata = '0;
        tick(); tick();
        cmp("reset_stall", 32'(stall), 32'h0);
        cmp("reset_req", 32'(req), 32'h0);
        rst = 0;
        tick();

        // Reset while a load sits in WAIT; a late valid must be dropped.
        mem_rd = 1; imm = 11'h0F0; rd = 3'd7;
        tick();
        mem_rd = 0; gnt = 1;
        tick();
        gnt = 0;
        tick();
        rst = 1;
        tick(); tick();
        rst = 0; valid = 1; rdata = 8'h5A;
        tick();
        valid = 0;
        cmp("rst_no_wr", 32'(wr_en), 32'h0);
        cmp("rst_stall", 32'(stall), 32'h0);
        cmp("rst_addr", 32'(dm_addr), 32'h0);
        tick();
        cmp("rst_no_wr2", 32'(wr_en), 32'h0);

        for (int r = 0; r < 5; r++) run_row(r);

        // Grant never arrives.
        mem_rd = 1; imm = 11'h155; rd = 3'd4; gnt = 0; valid = 0;
        tick();
        mem_rd = 0;
`ifdef CUS19_LD_TIMEOUT_EN
        c_err = 0;
        for (int c = 1; c <= 20 && c_err == 0; c++) begin
            if (err) c_err = c;
            else tick();
        end
        cmp("tmo_cycle", 32'(c_err), 32'd5);
        cmp("tmo_no_wr", 32'(wr_en), 32'h0);
        cmp("tmo_req_drop", 32'(req), 32'h0);
        tick();
        cmp("tmo_single_pulse", 32'(err), 32'h0);
`else
        c_err = 0;
        for (int c = 0; c < 300; c++) begin
            if (err) c_err++;
            tick();
        end
        cmp("no_tmo_err", 32'(c_err), 32'h0);
        cmp("no_tmo_req", 32'(req), 32'h1);
        cmp("no_tmo_addr", 32'(dm_addr), 32'h155);
        rst = 1;
        tick();
        rst = 0;
`endif
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) < 2);
            mem_rd = 1'($urandom);
            imm    = 11'($urandom);
            rd     = 3'($urandom);
            gnt    = ($urandom_range(0, 99) < 40);
            valid  = ($urandom_range(0, 99) < 40);
            rdata  = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
